// File: rtl/adder_io_pkg.sv
// Shared types and constants for the adder operand input path.
package adder_io_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        HAVE_A  = 2'b01,
        PRESENT = 2'b10
    } seq_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/switch_settle_edge.sv
// One asynchronous switch bit: synchroniser, settle counter and a single-cycle
// event pulse once the level has been stable high for SETTLE_CYCLES cycles.
module switch_settle_edge
    import adder_io_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_sync_level,
    output logic o_evt_pulse
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic [CW-1:0]          r_cnt;
    logic                   r_armed;
    logic                   w_level;
    logic                   w_hit;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Pulse on the edge where the counter reaches SETTLE_CYCLES, so the consumer
    // acts on that same edge.
    assign w_hit = w_level && r_armed && (r_cnt == CW'(SETTLE_CYCLES - 1));

    assign o_sync_level = w_level;
    assign o_evt_pulse  = w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            if (!w_level) begin
                r_cnt <= '0;
                // A switch still held across reset must be seen low (with a
                // genuine synchronised sample) before it can fire again.
                if (r_fill[SYNC_STAGES-1]) begin
                    r_armed <= 1'b1;
                end
            end else if (r_cnt != CW'(SETTLE_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Captures operand A then B from one switch bank on settled load strobes and
// offers the pair to the adder stage with a valid/ready handshake.
module adder_operand_sequencer
    import adder_io_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_load,
    input  logic             sw_clear,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       state_dbg,
    output logic             overrun
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_data_sync;
    logic [SYNC_STAGES-1:0]            r_clr_sync;
    logic [WIDTH-1:0]                  r_a;
    logic [WIDTH-1:0]                  r_b;
    logic                              r_valid;
    logic                              r_ovr;
    seq_state_t                        r_state;

    logic             w_load_level;
    logic             w_load_evt;
    logic             w_clear;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;

    switch_settle_edge #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_load (
        .clk          (clk),
        .rst          (rst),
        .i_sw         (sw_load),
        .o_sync_level (w_load_level),
        .o_evt_pulse  (w_load_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_sync <= '0;
            r_clr_sync  <= '0;
        end else begin
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], sw_data};
            r_clr_sync  <= {r_clr_sync[SYNC_STAGES-2:0], sw_clear};
        end
    end

    assign w_data  = r_data_sync[SYNC_STAGES-1];
    assign w_clear = r_clr_sync[SYNC_STAGES-1];
    assign w_xfer  = r_valid && out_ready;

    // Priority: reset, clear, transfer, load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_clear) begin
            r_state <= EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_load_evt) begin
                        r_a     <= w_data;
                        r_state <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (w_load_evt) begin
                        r_b     <= w_data;
                        r_state <= PRESENT;
                        r_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    // A load here is always dropped, even when it coincides
                    // with the transfer that frees the pair.
                    if (w_load_evt) begin
                        r_ovr <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign out_valid = r_valid;
    assign overrun   = r_ovr;
    assign state_dbg = r_state;

    logic w_unused;
    assign w_unused = w_load_level;

endmodule
